msu_data_server: RTL
====================

// Module: msu_data_server
// PURPOSE
//  Responder for the MSU-1 data-port fetch interface (data_addr/data_req/data_seek -> data/data_ack).
//  Serves byte reads from a 64-bit-wide DDR-style memory holding the MSU data file.
//  Holds a 2-line (2x8-byte) buffer with sequential next-line prefetch, so streaming $2001 reads hit in 1 cycle.
//  Sits in the top-level glue between the MSU block's data port and the DDR arbiter.
// PARAMETERS
//  ADDR_W    32     byte-address width of data_addr
//  MEM_BASE  29'h0  line (64-bit word) offset added to every memory address; wraps modulo 2^29
// PORTS
//  CLK        in   1       system clock; all logic on rising edge
//  RST_N      in   1       asynchronous active-low reset
//  data_addr  in   ADDR_W  byte address; sampled on the data_req or data_seek cycle only
//  data_req   in   1       1-cycle pulse: read byte at data_addr
//  data_seek  in   1       1-cycle pulse: discard buffer, reload from data_addr
//  data       out  8       byte result; valid and held from the data_ack cycle until the next ack
//  data_ack   out  1       1-cycle pulse: request or seek complete
//  mem_addr   out  29      line address = data_addr[31:3] + MEM_BASE
//  mem_req    out  1       level; held high until mem_ack
//  mem_ack    in   1       1-cycle pulse; mem_di valid in the same cycle
//  mem_di     in   64      line data; byte n = mem_di[8n+7:8n] (little-endian)
// BEHAVIOUR
//  Reset: data=0, data_ack=0, mem_req=0, mem_addr=0, both buffer entries invalid, FSM=IDLE, no pending op.
//  Buffer: entries E0/E1, each holding {valid, tag[28:0] = addr[31:3], line[63:0]}. Fill target = the entry not holding the line being served.
//  FSM states: IDLE, FETCH (demand miss), PREFETCH (next line), DRAIN (discard an in-flight fill after a seek).
//  Hit (data_req, tag match on a valid entry, FSM any state except DRAIN):
//   - data_ack and data are driven exactly 1 cycle after data_req.
//  Miss:
//   - IDLE: mem_req rises the next cycle -> FETCH.
//   - PREFETCH in flight to the same line: the req is held pending and acked in the cycle after that mem_ack.
//   - PREFETCH in flight to a different line: the req is held pending; a FETCH issues after the prefetch mem_ack.
//  FETCH: on mem_ack, write the line into the entry and mark it valid. data_ack plus the selected byte follow 1 cycle after mem_ack.
//  Prefetch trigger: after any ack for line L, if L+1 (mod 2^29) is not resident, enter PREFETCH for L+1 into the other entry. Otherwise go to IDLE.
//  data_seek:
//   - Both entries are invalidated that same cycle.
//   - Any pending data_req is dropped with no ack.
//   - If mem_req is high, go to DRAIN: wait for mem_ack, discard its data, then FETCH the seek line.
//   - Otherwise FETCH immediately.
//   - Seek completion = one data_ack the cycle after that line's fill; data = the byte at the seek address. The prefetch of L+1 follows.
//  Simultaneous data_req + data_seek: seek wins; req ignored.
//  A data_req while a previous one is un-acked is a protocol error. It is ignored; the bench asserts it never occurs.
//  mem_req: asserted with mem_addr stable; both held until mem_ack; deasserted the cycle after mem_ack. Never 2 outstanding.
//  mem_ack while mem_req=0: ignored.
//  Address wrap: line L=2^29-1 prefetches line 0; the MEM_BASE sum is truncated to 29 bits.
//  Reset asserted mid-fetch: everything returns to reset values immediately; a later stray mem_ack is ignored.
// STRUCTURE
//  Package msu_data_pkg: FSM state enum {IDLE,FETCH,PREFETCH,DRAIN}, LINE_BYTES=8, LINE_AW=29.
//  Sub-module msu_line_buf: 2-entry tag/data store with dual tag compare. Outputs: hit, hit_idx, byte_out. Inputs: fill port, invalidate-all.
//  Top: FSM, pending-request register, mem handshake, ack and data output registers.
// TESTING
//  1. Seek to 0x100 (mem_di=0x0706050403020100, mem_ack 5 cycles later) -> data_ack 1 cycle after mem_ack, data=0x00; then mem_req for line 0x21.
//  2. After 1, data_req at 0x101..0x107 -> each acked 1 cycle later with data 0x01..0x07; no mem_req while line 0x21 is already resident.
//  3. data_req 0x108 while the line-0x21 prefetch is in flight -> ack the cycle after the prefetch mem_ack with byte0; then a prefetch of line 0x22.
//  4. Seek 0x4000 during an in-flight fetch -> no ack for the old data; after that mem_ack, mem_addr=0x800 and a single ack after its fill.
//  5. MEM_BASE=29'h1FFFFFFF, seek 0x8 -> mem_addr=0x0; data_addr=0xFFFFFFF8 prefetch -> mem_addr=MEM_BASE-1 (wrap).
//  6. RST_N low while mem_req=1, release, inject mem_ack -> outputs stay at reset values; data_ack stays 0.

Source files
------------

// File: rtl/msu_data_pkg.sv
// Shared types and constants for the MSU data-port server.
package msu_data_pkg;

    localparam int LINE_BYTES = 8;
    localparam int LINE_AW    = 29;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH    = 2'd1,
        PREFETCH = 2'd2,
        DRAIN    = 2'd3
    } state_t;

    typedef logic [LINE_AW-1:0] line_tag_t;

    function automatic logic [7:0] line_byte(input logic [LINE_BYTES*8-1:0] line,
                                             input logic [2:0] off);
        return line[{off, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/msu_line_buf.sv
// Two-entry line store: one fill port, one served lookup (tag+offset) and one
// residency probe used to decide whether the next line needs a prefetch.
module msu_line_buf
    import msu_data_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      inv_all,
    input  logic                      fill_en,
    input  logic                      fill_idx,
    input  line_tag_t                 fill_tag,
    input  logic [LINE_BYTES*8-1:0]   fill_line,
    input  line_tag_t                 lookup_tag,
    input  logic [2:0]                lookup_off,
    output logic                      hit,
    output logic                      hit_idx,
    output logic [7:0]                byte_out,
    input  line_tag_t                 nxt_tag,
    output logic                      nxt_hit,
    output logic                      nxt_hit_idx
);

    logic [1:0]              valid_r;
    line_tag_t               tag_r  [2];
    logic [LINE_BYTES*8-1:0] line_r [2];
    logic [1:0]              match_s;
    logic [1:0]              nxt_match_s;

    // Entry storage; invalidate-all takes priority over a same-cycle fill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                tag_r[i]  <= '0;
                line_r[i] <= '0;
            end
        end else if (inv_all) begin
            valid_r <= 2'b00;
        end else if (fill_en) begin
            valid_r[fill_idx] <= 1'b1;
            tag_r[fill_idx]   <= fill_tag;
            line_r[fill_idx]  <= fill_line;
        end
    end

    // Dual tag compare for the served lookup and the next-line probe.
    always_comb begin
        match_s     = {valid_r[1] && (tag_r[1] == lookup_tag), valid_r[0] && (tag_r[0] == lookup_tag)};
        nxt_match_s = {valid_r[1] && (tag_r[1] == nxt_tag),    valid_r[0] && (tag_r[0] == nxt_tag)};
        hit         = |match_s;
        nxt_hit     = |nxt_match_s;
        if (match_s[0]) begin
            hit_idx = 1'b0;
        end else begin
            hit_idx = 1'b1;
        end
        if (nxt_match_s[0]) begin
            nxt_hit_idx = 1'b0;
        end else begin
            nxt_hit_idx = 1'b1;
        end
        byte_out = line_byte(line_r[hit_idx], lookup_off);
    end

endmodule

// File: rtl/msu_data_server.sv
// MSU-1 data-port responder: serves byte reads from a 64-bit line memory
// through a two-line buffer with sequential next-line prefetch.
module msu_data_server
    import msu_data_pkg::*;
#(
    parameter int        ADDR_W   = 32,
    parameter line_tag_t MEM_BASE = 29'h0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic                data_req,
    input  logic                data_seek,
    output logic [7:0]          data,
    output logic                data_ack,
    output logic [LINE_AW-1:0]  mem_addr,
    output logic                mem_req,
    input  logic                mem_ack,
    input  logic [63:0]         mem_di
);

    state_t     state_r;
    logic       pend_r, pf_go_r, fill_idx_r, served_idx_r;
    line_tag_t  pend_tag_r, cur_tag_r, mem_addr_r;
    logic [2:0] pend_off_r;
    logic [7:0] data_r;
    logic       data_ack_r, mem_req_r;

    line_tag_t  req_tag_s, nxt_tag_s, p_tag_s;
    logic [2:0] req_off_s, p_off_s;
    logic       ack_fire_s, fill_en_s;
    logic       buf_hit_s, buf_idx_s, nxt_hit_s, nxt_idx_s;
    logic [7:0] buf_byte_s, fill_byte_s;
    logic       accept_s, hit_s, miss_s, p_valid_s, nxt_res_s;

    assign req_tag_s  = data_addr[LINE_AW+2:3];
    assign req_off_s  = data_addr[2:0];
    assign ack_fire_s = mem_req_r && mem_ack;
    assign fill_en_s  = ack_fire_s && (state_r != DRAIN);
    assign nxt_tag_s  = ack_fire_s ? (cur_tag_r + 29'd1) : (req_tag_s + 29'd1);

    msu_line_buf u_line_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .inv_all     (data_seek),
        .fill_en     (fill_en_s),
        .fill_idx    (fill_idx_r),
        .fill_tag    (cur_tag_r),
        .fill_line   (mem_di),
        .lookup_tag  (req_tag_s),
        .lookup_off  (req_off_s),
        .hit         (buf_hit_s),
        .hit_idx     (buf_idx_s),
        .byte_out    (buf_byte_s),
        .nxt_tag     (nxt_tag_s),
        .nxt_hit     (nxt_hit_s),
        .nxt_hit_idx (nxt_idx_s)
    );

    // Request classification; a miss arriving in a fill's ack cycle joins that fill.
    always_comb begin
        accept_s  = data_req && !data_seek && !pend_r && (state_r != DRAIN);
        hit_s     = accept_s && buf_hit_s;
        miss_s    = accept_s && !buf_hit_s;
        p_valid_s = pend_r || miss_s;
        if (pend_r) begin
            p_tag_s = pend_tag_r;
            p_off_s = pend_off_r;
        end else begin
            p_tag_s = req_tag_s;
            p_off_s = req_off_s;
        end
        fill_byte_s = line_byte(mem_di, p_off_s);
        // The entry being overwritten by this fill does not count as resident.
        nxt_res_s = nxt_hit_s && !(ack_fire_s && (nxt_idx_s == fill_idx_r));
    end

    // Control FSM, pending request, memory handshake and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            pend_r       <= 1'b0;
            pend_tag_r   <= '0;
            pend_off_r   <= 3'd0;
            pf_go_r      <= 1'b0;
            fill_idx_r   <= 1'b0;
            served_idx_r <= 1'b0;
            cur_tag_r    <= '0;
            mem_addr_r   <= '0;
            mem_req_r    <= 1'b0;
            data_r       <= 8'd0;
            data_ack_r   <= 1'b0;
        end else begin
            data_ack_r <= 1'b0;
            if (data_seek) begin
                pend_r     <= 1'b1;
                pend_tag_r <= req_tag_s;
                pend_off_r <= req_off_s;
                fill_idx_r <= 1'b0;
                pf_go_r    <= 1'b0;
                if (mem_req_r && !mem_ack) begin
                    state_r <= DRAIN;
                end else begin
                    state_r    <= FETCH;
                    mem_req_r  <= 1'b1;
                    cur_tag_r  <= req_tag_s;
                    mem_addr_r <= req_tag_s + MEM_BASE;
                end
            end else begin
                if (hit_s) begin
                    data_ack_r   <= 1'b1;
                    data_r       <= buf_byte_s;
                    served_idx_r <= buf_idx_s;
                end
                case (state_r)
                    IDLE: begin
                        pf_go_r <= 1'b0;
                        if (pend_r) begin
                            state_r    <= FETCH;
                            mem_req_r  <= 1'b1;
                            cur_tag_r  <= pend_tag_r;
                            mem_addr_r <= pend_tag_r + MEM_BASE;
                        end else if (miss_s) begin
                            pend_r     <= 1'b1;
                            pend_tag_r <= req_tag_s;
                            pend_off_r <= req_off_s;
                            fill_idx_r <= ~served_idx_r;
                            state_r    <= FETCH;
                            mem_req_r  <= 1'b1;
                            cur_tag_r  <= req_tag_s;
                            mem_addr_r <= req_tag_s + MEM_BASE;
                        end else if (pf_go_r) begin
                            state_r    <= PREFETCH;
                            mem_req_r  <= 1'b1;
                            mem_addr_r <= cur_tag_r + MEM_BASE;
                        end else if (hit_s && !nxt_hit_s) begin
                            fill_idx_r <= ~buf_idx_s;
                            state_r    <= PREFETCH;
                            mem_req_r  <= 1'b1;
                            cur_tag_r  <= nxt_tag_s;
                            mem_addr_r <= nxt_tag_s + MEM_BASE;
                        end
                    end
                    FETCH, PREFETCH: begin
                        if (ack_fire_s) begin
                            mem_req_r <= 1'b0;
                            state_r   <= IDLE;
                            if (p_valid_s && (p_tag_s == cur_tag_r)) begin
                                data_ack_r   <= 1'b1;
                                data_r       <= fill_byte_s;
                                pend_r       <= 1'b0;
                                served_idx_r <= fill_idx_r;
                                pf_go_r      <= !nxt_res_s;
                                cur_tag_r    <= nxt_tag_s;
                                fill_idx_r   <= ~fill_idx_r;
                            end else if (p_valid_s) begin
                                // Different line wanted: fetch it next, keeping the prefetched line.
                                pend_r     <= 1'b1;
                                pend_tag_r <= p_tag_s;
                                pend_off_r <= p_off_s;
                                fill_idx_r <= ~fill_idx_r;
                            end
                        end else if (miss_s) begin
                            pend_r     <= 1'b1;
                            pend_tag_r <= req_tag_s;
                            pend_off_r <= req_off_s;
                        end
                    end
                    DRAIN: begin
                        if (ack_fire_s) begin
                            mem_req_r <= 1'b0;
                            state_r   <= IDLE;
                        end
                    end
                    default: state_r <= IDLE;
                endcase
            end
        end
    end

    assign data     = data_r;
    assign data_ack = data_ack_r;
    assign mem_addr = mem_addr_r;
    assign mem_req  = mem_req_r;

endmodule
